multicycle_pc_controller: RTL and testbench

Main control FSM for the multicycle RV32I core. It sequences the program counter (PCSrc 00 = PCPlus4, 01 = PCTarget, 10 = ALUResult) and the shared instruction/data memory port. It also drives the register file, IR and ALU mux controls from the latched instruction fields. It replaces hard-wired every-cycle PC update with an explicit PCEn and a memory ready handshake.

---
 rtl/multicycle_pc_controller_pkg.sv | 64 ++++++
 rtl/multicycle_pc_controller_alu_decoder.sv | 38 +++
 rtl/multicycle_pc_controller.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_pc_controller.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pc_controller_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// mux selects and ALU operation codes.
package riscv_pkg;

    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEMADR   = 4'd3,
        ST_MEMREAD  = 4'd4,
        ST_MEMWB    = 4'd5,
        ST_MEMWRITE = 4'd6,
        ST_EXECR    = 4'd7,
        ST_EXECI    = 4'd8,
        ST_ALUWB    = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_JALR     = 4'd12,
        ST_HALT     = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_ALU    = 2'b10;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC  = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
            OP_BRANCH, OP_JAL, OP_JALR: is_legal_op = 1'b1;
            default:                    is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_pc_controller_alu_decoder.sv
// Combinational ALUOp/funct decoder producing the ALU operation code.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    // Map ALUOp and instruction fields to an ALU operation.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: begin
                        // Only R-type (op[5]=1) uses funct7b5 for sub; addi never does.
                        if (op5 && funct7b5) begin
                            alu_control = ALU_SUB;
                        end else begin
                            alu_control = ALU_ADD;
                        end
                    end
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_pc_controller.sv
// Main control FSM of the multicycle RV32I core. Define ILLEGAL_TRAP_EN to make
// illegal opcodes halt with a sticky IllegalInstr flag instead of acting as NOPs.
module multicycle_pc_controller
    import riscv_pkg::*;
#(
    parameter int unsigned RESET_HOLD_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCEn,
    output logic [1:0] PCSrc,
    output logic       AdrSrc,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       InstrRetired,
    output logic       IllegalInstr
);

    localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD_CYCLES - 1);

    state_t     state;
    logic [3:0] hold_cnt;
    logic [1:0] alu_op;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControl)
    );

    // State register and next-state sequencing, including the post-reset hold.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= ST_RESET;
            hold_cnt <= 4'd0;
        end else begin
            case (state)
                ST_RESET: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= ST_FETCH;
                        hold_cnt <= 4'd0;
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                ST_FETCH:    if (MemReady) state <= ST_DECODE;
                ST_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: state <= ST_MEMADR;
                        OP_RTYPE:          state <= ST_EXECR;
                        OP_ITYPE:          state <= ST_EXECI;
                        OP_BRANCH:         state <= ST_BRANCH;
                        OP_JAL:            state <= ST_JUMP;
                        OP_JALR:           state <= ST_JALR;
`ifdef ILLEGAL_TRAP_EN
                        default:           state <= ST_HALT;
`else
                        default:           state <= ST_FETCH;
`endif
                    endcase
                end
                ST_MEMADR:   state <= (op == OP_STORE) ? ST_MEMWRITE : ST_MEMREAD;
                ST_MEMREAD:  if (MemReady) state <= ST_MEMWB;
                ST_MEMWRITE: if (MemReady) state <= ST_FETCH;
                ST_EXECR:    state <= ST_ALUWB;
                ST_EXECI:    state <= ST_ALUWB;
                ST_HALT:     state <= ST_HALT;
                ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_JUMP, ST_JALR: state <= ST_FETCH;
                default:     state <= ST_RESET;
            endcase
        end
    end

    // Control outputs from the current state; Reset forces every output low at once.
    always_comb begin
        PCEn         = 1'b0;
        PCSrc        = PCSRC_PLUS4;
        AdrSrc       = 1'b0;
        MemReq       = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        ResultSrc    = RES_ALU;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_RS2;
        alu_op       = ALUOP_ADD;
        InstrRetired = 1'b0;
        IllegalInstr = 1'b0;
        if (Reset) begin
            PCEn = 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    MemReq  = 1'b1;
                    IRWrite = MemReady;
                    PCEn    = MemReady;
                end
                ST_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
                    InstrRetired = 1'b0;
`else
                    InstrRetired = !is_legal_op(op);
`endif
                end
                ST_MEMADR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                end
                ST_MEMREAD: begin
                    MemReq = 1'b1;
                    AdrSrc = 1'b1;
                end
                ST_MEMWB: begin
                    RegWrite     = 1'b1;
                    ResultSrc    = RES_MEM;
                    InstrRetired = 1'b1;
                end
                ST_MEMWRITE: begin
                    MemReq       = 1'b1;
                    MemWrite     = 1'b1;
                    AdrSrc       = 1'b1;
                    InstrRetired = MemReady;
                end
                ST_EXECR: begin
                    ALUSrcA = SRCA_RS1;
                    alu_op  = ALUOP_FUNCT;
                end
                ST_EXECI: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    alu_op  = ALUOP_FUNCT;
                end
                ST_ALUWB: begin
                    RegWrite     = 1'b1;
                    InstrRetired = 1'b1;
                end
                ST_BRANCH: begin
                    ALUSrcA      = SRCA_RS1;
                    alu_op       = ALUOP_SUB;
                    PCEn         = Zero ^ funct3[0];
                    PCSrc        = (Zero ^ funct3[0]) ? PCSRC_TARGET : PCSRC_PLUS4;
                    InstrRetired = 1'b1;
                end
                ST_JUMP: begin
                    PCEn         = 1'b1;
                    PCSrc        = PCSRC_TARGET;
                    RegWrite     = 1'b1;
                    ResultSrc    = RES_PC;
                    InstrRetired = 1'b1;
                end
                ST_JALR: begin
                    ALUSrcA      = SRCA_RS1;
                    ALUSrcB      = SRCB_IMM;
                    PCEn         = 1'b1;
                    PCSrc        = PCSRC_ALU;
                    RegWrite     = 1'b1;
                    ResultSrc    = RES_PC;
                    InstrRetired = 1'b1;
                end
                ST_HALT: begin
`ifdef ILLEGAL_TRAP_EN
                    IllegalInstr = 1'b1;
`else
                    IllegalInstr = 1'b0;
`endif
                end
                default: PCEn = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_pc_controller.sv
// Scoreboard bench for multicycle_pc_controller: directed per-cycle vectors with
// hand-computed output bundles, checked by an independent negedge monitor.
module tb_multicycle_pc_controller;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero, MemReady;
    logic       PCEn, AdrSrc, MemReq, MemWrite, IRWrite, RegWrite, InstrRetired, IllegalInstr;
    logic [1:0] PCSrc, ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [18:0] vec;
        string       name;
    } exp_t;
    exp_t sb[$];

    multicycle_pc_controller #(.RESET_HOLD_CYCLES(1)) dut (
        .CLK(CLK), .Reset(Reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCEn(PCEn), .PCSrc(PCSrc), .AdrSrc(AdrSrc),
        .MemReq(MemReq), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .InstrRetired(InstrRetired), .IllegalInstr(IllegalInstr)
    );

    always #5 CLK = ~CLK;

    function automatic logic [18:0] mk(input logic pcen, input logic [1:0] pcsrc,
                                       input logic adr, input logic req, input logic wr,
                                       input logic ir, input logic rw, input logic [1:0] res,
                                       input logic [1:0] sa, input logic [1:0] sbv,
                                       input logic [2:0] alu, input logic ret, input logic ill);
        return {pcen, pcsrc, adr, req, wr, ir, rw, res, sa, sbv, alu, ret, ill};
    endfunction

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111, BADOP = 7'b0000000;

    logic [18:0] e_zero, e_fetch, e_fwait, e_execr_add, e_execr_sub, e_execi_or, e_aluwb;
    logic [18:0] e_memadr, e_memrd, e_memwb, e_mwr_wait, e_mwr_go;
    logic [18:0] e_br_taken, e_br_not, e_jal, e_jalr, e_halt, e_dec_nop;

    // Monitor: one expected bundle per cycle, compared mid-cycle.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [18:0] got;
            e   = sb.pop_front();
            got = {PCEn, PCSrc, AdrSrc, MemReq, MemWrite, IRWrite, RegWrite, ResultSrc,
                   ALUSrcA, ALUSrcB, ALUControl, InstrRetired, IllegalInstr};
            total++;
            if (got !== e.vec) begin
                bad++;
                $display("FAIL %s: got %b expected %b", e.name, got, e.vec);
            end
        end
    end

    task automatic step(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                        input logic f7, input logic z, input logic rdy,
                        input logic [18:0] e, input string nm);
        exp_t x;
        @(posedge CLK);
        #1;
        Reset = rst; op = o; funct3 = f3; funct7b5 = f7; Zero = z; MemReady = rdy;
        x.vec  = e;
        x.name = nm;
        sb.push_back(x);
    endtask

    initial begin
        Reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b0;
        e_zero      = 19'd0;
        e_fetch     = mk(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
        e_fwait     = mk(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
        e_execr_add = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0);
        e_execr_sub = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 1'b0, 1'b0);
        e_execi_or  = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b011, 1'b0, 1'b0);
        e_aluwb     = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0);
        e_memadr    = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0, 1'b0);
        e_memrd     = mk(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
        e_memwb     = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0);
        e_mwr_wait  = mk(1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
        e_mwr_go    = mk(1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0);
        e_br_taken  = mk(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 1'b1, 1'b0);
        e_br_not    = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 1'b1, 1'b0);
        e_jal       = mk(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0);
        e_jalr      = mk(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b10, 2'b01, 3'b000, 1'b1, 1'b0);
        e_halt      = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1);
        e_dec_nop   = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0);

        // Reset, one RESET hold cycle, then R-type add.
        step(1'b1, R, 3'b000, 1'b0, 1'b0, 1'b1, e_zero,      "rst_a");
        step(1'b1, R, 3'b000, 1'b0, 1'b0, 1'b1, e_zero,      "rst_b");
        step(1'b0, R, 3'b000, 1'b0, 1'b0, 1'b1, e_zero,      "reset_hold");
        step(1'b0, R, 3'b000, 1'b0, 1'b0, 1'b1, e_fetch,     "add_fetch");
        step(1'b0, R, 3'b000, 1'b0, 1'b0, 1'b1, e_zero,      "add_decode");
        step(1'b0, R, 3'b000, 1'b0, 1'b0, 1'b1, e_execr_add, "add_execr");
        step(1'b0, R, 3'b000, 1'b0, 1'b0, 1'b1, e_aluwb,     "add_aluwb");
        // R-type sub with one fetch wait state.
        step(1'b0, R, 3'b000, 1'b1, 1'b0, 1'b0, e_fwait,     "sub_fetch_wait");
        step(1'b0, R, 3'b000, 1'b1, 1'b0, 1'b1, e_fetch,     "sub_fetch");
        step(1'b0, R, 3'b000, 1'b1, 1'b0, 1'b1, e_zero,      "sub_decode");
        step(1'b0, R, 3'b000, 1'b1, 1'b0, 1'b1, e_execr_sub, "sub_execr");
        step(1'b0, R, 3'b000, 1'b1, 1'b0, 1'b1, e_aluwb,     "sub_aluwb");
        // ori: funct7b5 set but I-type must still decode on funct3 only.
        step(1'b0, I, 3'b110, 1'b1, 1'b0, 1'b1, e_fetch,     "ori_fetch");
        step(1'b0, I, 3'b110, 1'b1, 1'b0, 1'b1, e_zero,      "ori_decode");
        step(1'b0, I, 3'b110, 1'b1, 1'b0, 1'b1, e_execi_or,  "ori_execi");
        step(1'b0, I, 3'b110, 1'b1, 1'b0, 1'b1, e_aluwb,     "ori_aluwb");
        // lw with three MEMREAD wait cycles.
        step(1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b1, e_fetch,    "lw_fetch");
        step(1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b1, e_zero,     "lw_decode");
        step(1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b1, e_memadr,   "lw_memadr");
        step(1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b0, e_memrd,    "lw_memread_w1");
        step(1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b0, e_memrd,    "lw_memread_w2");
        step(1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b0, e_memrd,    "lw_memread_w3");
        step(1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b1, e_memrd,    "lw_memread_go");
        step(1'b0, LW, 3'b010, 1'b0, 1'b0, 1'b1, e_memwb,    "lw_memwb");
        // Branches: beq taken, bne not taken, beq not taken, funct3[2:1] ignored.
        step(1'b0, BR, 3'b000, 1'b0, 1'b1, 1'b1, e_fetch,    "beq_fetch");
        step(1'b0, BR, 3'b000, 1'b0, 1'b1, 1'b1, e_zero,     "beq_decode");
        step(1'b0, BR, 3'b000, 1'b0, 1'b1, 1'b1, e_br_taken, "beq_taken");
        step(1'b0, BR, 3'b001, 1'b0, 1'b1, 1'b1, e_fetch,    "bne_fetch");
        step(1'b0, BR, 3'b001, 1'b0, 1'b1, 1'b1, e_zero,     "bne_decode");
        step(1'b0, BR, 3'b001, 1'b0, 1'b1, 1'b1, e_br_not,   "bne_not_taken");
        step(1'b0, BR, 3'b000, 1'b0, 1'b0, 1'b1, e_fetch,    "beq0_fetch");
        step(1'b0, BR, 3'b000, 1'b0, 1'b0, 1'b1, e_zero,     "beq0_decode");
        step(1'b0, BR, 3'b000, 1'b0, 1'b0, 1'b1, e_br_not,   "beq_not_taken");
        step(1'b0, BR, 3'b100, 1'b0, 1'b1, 1'b1, e_fetch,    "b100_fetch");
        step(1'b0, BR, 3'b100, 1'b0, 1'b1, 1'b1, e_zero,     "b100_decode");
        step(1'b0, BR, 3'b100, 1'b0, 1'b1, 1'b1, e_br_taken, "b100_taken");
        // jal and jalr.
        step(1'b0, JL, 3'b000, 1'b0, 1'b0, 1'b1, e_fetch,    "jal_fetch");
        step(1'b0, JL, 3'b000, 1'b0, 1'b0, 1'b1, e_zero,     "jal_decode");
        step(1'b0, JL, 3'b000, 1'b0, 1'b0, 1'b1, e_jal,      "jal_jump");
        step(1'b0, JR, 3'b000, 1'b0, 1'b0, 1'b1, e_fetch,    "jalr_fetch");
        step(1'b0, JR, 3'b000, 1'b0, 1'b0, 1'b1, e_zero,     "jalr_decode");
        step(1'b0, JR, 3'b000, 1'b0, 1'b0, 1'b1, e_jalr,     "jalr_exec");
        // sw with one wait, then sw interrupted by reset mid-MEMWRITE.
        step(1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b1, e_fetch,    "sw_fetch");
        step(1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b1, e_zero,     "sw_decode");
        step(1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b1, e_memadr,   "sw_memadr");
        step(1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b0, e_mwr_wait, "sw_memwrite_wait");
        step(1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b1, e_mwr_go,   "sw_memwrite_go");
        step(1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b1, e_fetch,    "sw2_fetch");
        step(1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b1, e_zero,     "sw2_decode");
        step(1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b1, e_memadr,   "sw2_memadr");
        step(1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b0, e_mwr_wait, "sw2_memwrite_wait");
        step(1'b1, SW, 3'b010, 1'b0, 1'b0, 1'b1, e_zero,     "sw2_reset_now");
        step(1'b1, SW, 3'b010, 1'b0, 1'b0, 1'b1, e_zero,     "sw2_reset_edge");
        step(1'b0, SW, 3'b010, 1'b0, 1'b0, 1'b1, e_zero,     "sw2_reset_hold");
        // Illegal opcode.
        step(1'b0, BADOP, 3'b000, 1'b0, 1'b0, 1'b1, e_fetch, "ill_fetch");
`ifdef ILLEGAL_TRAP_EN
        step(1'b0, BADOP, 3'b000, 1'b0, 1'b0, 1'b1, e_zero,  "ill_decode");
        step(1'b0, R, 3'b000, 1'b0, 1'b0, 1'b1, e_halt,      "halt_1");
        step(1'b0, R, 3'b000, 1'b0, 1'b0, 1'b1, e_halt,      "halt_2");
        step(1'b1, R, 3'b000, 1'b0, 1'b0, 1'b1, e_zero,      "halt_reset");
        step(1'b0, R, 3'b000, 1'b0, 1'b0, 1'b1, e_zero,      "halt_reset_hold");
        step(1'b0, R, 3'b000, 1'b0, 1'b0, 1'b1, e_fetch,     "halt_refetch");
`else
        step(1'b0, BADOP, 3'b000, 1'b0, 1'b0, 1'b1, e_dec_nop, "ill_decode_nop");
        step(1'b0, R, 3'b000, 1'b0, 1'b0, 1'b1, e_fetch,     "ill_refetch");
`endif
        @(posedge CLK);
        @(posedge CLK);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
